mem_access_ctrl: RTL and testbench

Load/store sequencer between the pipeline's MEM stage and the data memory port. Accepts one load or store request at a time and checks alignment. Drives a request/grant memory handshake with byte enables and lane-replicated store data. Waits for read data, then returns it aligned and sign- or zero-extended (LB/LBU/LH/LHU/LW). While busy it stalls the pipeline.

---
 rtl/mem_ctrl_pkg.sv | 20 ++
 rtl/load_align_ext.sv | 28 ++
 rtl/mem_access_ctrl.sv | 115 +++++++++++
 tb/tb_mem_access_ctrl.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/mem_ctrl_pkg.sv
// mem_ctrl_pkg: shared encodings and helpers for the load/store sequencer.
//   SZ_*      : request size encodings (2'b11 is treated as a word)
//   state_t   : sequencer FSM states
//   calc_be   : byte enables from size and byte offset
//   misaligned: alignment check from size and byte offset
package mem_ctrl_pkg;
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_WAIT, ST_RESP} state_t;

    function automatic logic [3:0] calc_be(input logic [1:0] size, input logic [1:0] off);
        return size[1] ? 4'hf : size[0] ? (off[1] ? 4'hc : 4'h3) : (4'h1 << off);
    endfunction

    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
        return size[1] ? (off != 2'b00) : (size[0] & off[0]);
    endfunction
endpackage

// File: rtl/load_align_ext.sv
// load_align_ext: selects the addressed lane of a read word and sign/zero extends it.
//   i_word     : raw little-endian memory word
//   i_size     : access size (byte/half/word)
//   i_off      : byte offset within the word
//   i_unsigned : 1 = zero-extend, 0 = sign-extend
//   o_data     : right-justified extended result
module load_align_ext
    import mem_ctrl_pkg::*;
(
    input  logic [31:0] i_word,
    input  logic [1:0]  i_size,
    input  logic [1:0]  i_off,
    input  logic        i_unsigned,
    output logic [31:0] o_data
);
    logic [31:0] w_shift;
    logic [15:0] w_half;
    logic        w_bsign;
    logic        w_hsign;

    assign w_shift = i_word >> {i_off, 3'b000};
    assign w_half  = i_off[1] ? i_word[31:16] : i_word[15:0];
    assign w_bsign = ~i_unsigned & w_shift[7];
    assign w_hsign = ~i_unsigned & w_half[15];
    assign o_data  = i_size[1] ? i_word :
                     i_size[0] ? {{16{w_hsign}}, w_half} :
                                 {{24{w_bsign}}, w_shift[7:0]};
endmodule

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: one-at-a-time load/store sequencer between MEM stage and data memory.
//   i_req_* / o_req_ready : pipeline request handshake (we, size, unsigned, addr, wdata)
//   o_stall               : pipeline hold while a request is in flight
//   o_mem_* / i_mem_gnt   : memory request/grant with byte enables and replicated store data
//   i_mem_rvalid/rdata    : memory read return
//   o_rsp_valid/data/err  : one-cycle completion with extended load data or misalign error
module mem_access_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_req_valid,
    output logic              o_req_ready,
    input  logic              i_req_we,
    input  logic [1:0]        i_req_size,
    input  logic              i_req_unsigned,
    input  logic [ADDR_W-1:0] i_req_addr,
    input  logic [31:0]       i_req_wdata,
    output logic              o_stall,
    output logic              o_mem_req,
    input  logic              i_mem_gnt,
    output logic              o_mem_we,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [3:0]        o_mem_be,
    output logic [31:0]       o_mem_wdata,
    input  logic              i_mem_rvalid,
    input  logic [31:0]       i_mem_rdata,
    output logic              o_rsp_valid,
    output logic [31:0]       o_rsp_data,
    output logic              o_rsp_err
);
    state_t            r_state;
    state_t            w_next;
    logic              r_we;
    logic [1:0]        r_size;
    logic              r_unsigned;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wdata;
    logic [31:0]       r_rdata;
    logic              r_err;
    logic [31:0]       w_load;
    logic              w_accept;

    assign w_accept = (r_state == ST_IDLE) && i_req_valid;

    load_align_ext u_align (
        .i_word     (i_mem_rdata),
        .i_size     (r_size),
        .i_off      (r_addr[1:0]),
        .i_unsigned (r_unsigned),
        .o_data     (w_load)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_next;
    end

    // Misaligned requests skip the memory entirely and report straight from RESP.
    always_comb begin
        w_next      = r_state;
        o_req_ready = 1'b0;
        o_stall     = 1'b1;
        o_mem_req   = 1'b0;
        o_rsp_valid = 1'b0;
        case (r_state)
            ST_IDLE: begin
                o_req_ready = 1'b1;
                o_stall     = 1'b0;
                if (i_req_valid) w_next = misaligned(i_req_size, i_req_addr[1:0]) ? ST_RESP : ST_REQ;
            end
            ST_REQ: begin
                o_mem_req = 1'b1;
                if (i_mem_gnt) w_next = r_we ? ST_RESP : ST_WAIT;
            end
            ST_WAIT: if (i_mem_rvalid) w_next = ST_RESP;
            default: begin
                o_rsp_valid = 1'b1;
                w_next      = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_we       <= 1'b0;
            r_size     <= 2'b00;
            r_unsigned <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_rdata    <= '0;
            r_err      <= 1'b0;
        end else if (w_accept) begin
            r_we       <= i_req_we;
            r_size     <= i_req_size;
            r_unsigned <= i_req_unsigned;
            r_addr     <= i_req_addr;
            r_wdata    <= i_req_wdata;
            r_rdata    <= '0;
            r_err      <= misaligned(i_req_size, i_req_addr[1:0]);
        end else if (r_state == ST_WAIT && i_mem_rvalid) begin
            r_rdata    <= w_load;
        end
    end

    assign o_mem_we    = o_mem_req & r_we;
    assign o_mem_be    = o_mem_req ? calc_be(r_size, r_addr[1:0]) : 4'h0;
    assign o_mem_addr  = {r_addr[ADDR_W-1:2], 2'b00};
    assign o_mem_wdata = r_size[1] ? r_wdata :
                         r_size[0] ? {2{r_wdata[15:0]}} : {4{r_wdata[7:0]}};
    assign o_rsp_data  = r_rdata;
    assign o_rsp_err   = o_rsp_valid & r_err;
endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl: directed self-checking bench for mem_access_ctrl.
module tb_mem_access_ctrl;
    import mem_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_unsigned = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        stall;
    logic        mem_req;
    logic        mem_gnt = 1'b0;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        rsp_err;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mem_access_ctrl #(.ADDR_W(32)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_req_valid    (req_valid),
        .o_req_ready    (req_ready),
        .i_req_we       (req_we),
        .i_req_size     (req_size),
        .i_req_unsigned (req_unsigned),
        .i_req_addr     (req_addr),
        .i_req_wdata    (req_wdata),
        .o_stall        (stall),
        .o_mem_req      (mem_req),
        .i_mem_gnt      (mem_gnt),
        .o_mem_we       (mem_we),
        .o_mem_addr     (mem_addr),
        .o_mem_be       (mem_be),
        .o_mem_wdata    (mem_wdata),
        .i_mem_rvalid   (mem_rvalid),
        .i_mem_rdata    (mem_rdata),
        .o_rsp_valid    (rsp_valid),
        .o_rsp_data     (rsp_data),
        .o_rsp_err      (rsp_err)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic we, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata);
        req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
        req_addr = addr; req_wdata = wdata;
        chk("accept_ready", {31'd0, req_ready}, 32'd1);
        tick();
        req_valid = 1'b0; req_addr = 32'hDEAD_BEEF; req_wdata = 32'hFFFF_FFFF;
    endtask

    task automatic do_load(input string tag, input logic [1:0] size, input logic uns,
                           input logic [31:0] addr, input logic [31:0] rdata,
                           input logic [3:0] exp_be, input logic [31:0] exp_data);
        issue(1'b0, size, uns, addr, 32'h0);
        chk({tag, "_req"},   {31'd0, mem_req}, 32'd1);
        chk({tag, "_addr"},  mem_addr, {addr[31:2], 2'b00});
        chk({tag, "_be"},    {28'd0, mem_be}, {28'd0, exp_be});
        chk({tag, "_we"},    {31'd0, mem_we}, 32'd0);
        chk({tag, "_stall"}, {31'd0, stall}, 32'd1);
        mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0;
        chk({tag, "_wait"}, {30'd0, mem_req, rsp_valid}, 32'd0);
        mem_rvalid = 1'b1; mem_rdata = rdata;
        tick();
        mem_rvalid = 1'b0; mem_rdata = 32'h0;
        chk({tag, "_vld"},  {31'd0, rsp_valid}, 32'd1);
        chk({tag, "_err"},  {31'd0, rsp_err}, 32'd0);
        chk({tag, "_data"}, rsp_data, exp_data);
        tick();
        chk({tag, "_done"}, {30'd0, req_ready, rsp_valid}, 32'd2);
    endtask

    initial begin
        #2;
        chk("rst_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_outs",  {27'd0, stall, mem_req, mem_we, rsp_valid, rsp_err}, 32'd0);
        chk("rst_be",    {28'd0, mem_be}, 32'd0);
        chk("rst_data",  rsp_data, 32'd0);
        #10 rst_n = 1'b1;
        tick();

        do_load("lbu", SZ_BYTE, 1'b1, 32'h1003, 32'h80AA55CC, 4'b1000, 32'h0000_0080);
        do_load("lb",  SZ_BYTE, 1'b0, 32'h1003, 32'h80AA55CC, 4'b1000, 32'hFFFF_FF80);
        do_load("lb1", SZ_BYTE, 1'b0, 32'h1001, 32'h80AA55CC, 4'b0010, 32'h0000_0055);
        do_load("lh",  SZ_HALF, 1'b0, 32'h2002, 32'h9ABC1234, 4'b1100, 32'hFFFF_9ABC);
        do_load("lhu", SZ_HALF, 1'b1, 32'h2000, 32'h9ABC1234, 4'b0011, 32'h0000_1234);
        do_load("lhs", SZ_HALF, 1'b0, 32'h2000, 32'h0000_8001, 4'b0011, 32'hFFFF_8001);
        do_load("lw",  SZ_WORD, 1'b0, 32'h2004, 32'h8765_4321, 4'b1111, 32'h8765_4321);

        // store byte with grant held off for three cycles
        issue(1'b1, SZ_BYTE, 1'b0, 32'h3001, 32'hFFFF_FF5A);
        for (int i = 0; i < 4; i++) begin
            if (i == 3) mem_gnt = 1'b1;
            chk("sb_req",   {31'd0, mem_req}, 32'd1);
            chk("sb_addr",  mem_addr, 32'h3000);
            chk("sb_be",    {28'd0, mem_be}, 32'h2);
            chk("sb_wdata", mem_wdata, 32'h5A5A_5A5A);
            chk("sb_we",    {31'd0, mem_we}, 32'd1);
            chk("sb_stall", {31'd0, stall}, 32'd1);
            tick();
        end
        mem_gnt = 1'b0;
        chk("sb_rsp", {28'd0, stall, mem_req, rsp_valid, rsp_err}, 32'b1010);
        chk("sb_data", rsp_data, 32'd0);
        tick();
        chk("sb_idle", {31'd0, stall}, 32'd0);

        // misaligned word and half
        issue(1'b0, SZ_WORD, 1'b0, 32'h4002, 32'h0);
        chk("lw_mis", {29'd0, mem_req, rsp_valid, rsp_err}, 32'b011);
        chk("lw_mis_data", rsp_data, 32'd0);
        tick();
        issue(1'b1, SZ_HALF, 1'b0, 32'h4003, 32'h1234);
        chk("sh_mis", {29'd0, mem_req, rsp_valid, rsp_err}, 32'b011);
        tick();

        // aligned store word: not an error
        issue(1'b1, SZ_WORD, 1'b0, 32'h4000, 32'hCAFE_F00D);
        chk("sw_req",   {31'd0, mem_req}, 32'd1);
        chk("sw_be",    {28'd0, mem_be}, 32'hF);
        chk("sw_wdata", mem_wdata, 32'hCAFE_F00D);
        mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0;
        chk("sw_rsp", {30'd0, rsp_valid, rsp_err}, 32'b10);
        tick();

        // store half replication
        issue(1'b1, SZ_HALF, 1'b0, 32'h4002, 32'hFFFF_BEEF);
        chk("sh_be",    {28'd0, mem_be}, 32'hC);
        chk("sh_wdata", mem_wdata, 32'hBEEF_BEEF);
        mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0;
        tick();

        // stray rvalid in IDLE and REQ, and alongside gnt
        mem_rvalid = 1'b1; mem_rdata = 32'h1111_1111;
        tick();
        chk("stray_idle", {30'd0, req_ready, rsp_valid}, 32'b10);
        issue(1'b0, SZ_WORD, 1'b0, 32'h6000, 32'h0);
        mem_rdata = 32'h2222_2222;
        tick();
        chk("stray_req", {30'd0, mem_req, rsp_valid}, 32'b10);
        mem_gnt = 1'b1; mem_rdata = 32'h3333_3333;
        tick();
        mem_gnt = 1'b0; mem_rvalid = 1'b0;
        chk("gnt_rv_same", {30'd0, mem_req, rsp_valid}, 32'b00);
        chk("gnt_rv_stall", {31'd0, stall}, 32'd1);
        mem_rvalid = 1'b1; mem_rdata = 32'h4444_4444;
        tick();
        mem_rvalid = 1'b0;
        chk("stray_vld",  {31'd0, rsp_valid}, 32'd1);
        chk("stray_data", rsp_data, 32'h4444_4444);
        tick();

        // reset while waiting for read data
        issue(1'b0, SZ_WORD, 1'b0, 32'h7000, 32'h0);
        mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0;
        chk("pre_rst_stall", {31'd0, stall}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst", {28'd0, mem_req, stall, rsp_valid, req_ready}, 32'b0001);
        #2 rst_n = 1'b1;
        mem_rvalid = 1'b1; mem_rdata = 32'h5555_5555;
        tick();
        mem_rvalid = 1'b0;
        chk("post_rst_rv", {29'd0, stall, rsp_valid, req_ready}, 32'b001);
        chk("post_rst_data", rsp_data, 32'd0);
        do_load("lw_after", SZ_WORD, 1'b0, 32'h7000, 32'h1357_9BDF, 4'b1111, 32'h1357_9BDF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
